fetch_controller: RTL and testbench
===================================

# fetch_controller

Instruction-fetch sequencer for the RISC-V pipeline. It owns the program counter and drives the combinational instruction memory address. It captures fetched words into a small FIFO and hands them to the IF/ID stage over a valid/ready handshake. It also handles branch/jump redirects, halt requests and out-of-range fetch faults.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `MEM_DEPTH`, default 51: number of 32-bit words in instruction memory; the valid word index range is 0..MEM_DEPTH-1.
- `BUF_DEPTH`, default 2: fetch FIFO entries (power of two, ≥2).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `redirect_valid_i` in 1: branch/jump taken; flush and load a new PC.
- `redirect_pc_i` in 32: redirect target.
- `halt_i` in 1: stop issuing new fetches (level).
- `imem_pc_o` out 32: byte address to instruction memory (equals the internal `pc`).
- `imem_inst_i` in 32: instruction word returned combinationally for `imem_pc_o`.
- `if_valid_o` out 1: FIFO head valid.
- `if_pc_o` out 32: PC of FIFO head.
- `if_inst_o` out 32: instruction of FIFO head.
- `if_ready_i` in 1: IF/ID accepts the head this cycle.
- `fault_o` out 1: fetch fault latched.
- `fault_pc_o` out 32: offending PC.

## Operation
- **States:**
  - FETCH: normal operation.
  - HALT: `halt_i` high, no fetch.
  - FAULT: bad PC, no fetch.
- **Push condition:** in FETCH, `push = !halt_i && !redirect_valid_i && addr_ok && (count < BUF_DEPTH || pop)`.
  - `addr_ok = (pc[1:0]==0) && ((pc>>2) < MEM_DEPTH)`.
  - On push, enqueue {pc, imem_inst_i} and set pc <= pc + 4. The adder wraps modulo 2^32.
- **Pop:** `pop = if_valid_o && if_ready_i`. Head outputs are registered FIFO contents; `if_valid_o = (count != 0)`.
- **Fault:** in FETCH with `!halt_i && !redirect_valid_i && !addr_ok`:
  - go to FAULT; `fault_o <= 1`; `fault_pc_o <= pc`; pc holds.
  - Already-buffered entries keep draining.
- **FAULT exit:** leaves only on redirect or reset. On redirect, clear `fault_o`, go to FETCH (or HALT if `halt_i`).
- **HALT:** entered from FETCH when `halt_i` is high. Returns to FETCH the cycle after `halt_i` falls. The FIFO drains normally while halted.
- **Redirect (any state):**
  - pc <= redirect_pc_i; count <= 0 (flush), the FIFO read/write pointers also return to 0.
  - No push that cycle.
  - A pop in the same cycle is still a valid transfer: the consumer has taken the old head.
  - Redirect has priority over halt for the pc/flush update, and over fault detection.
- **Redirect to a bad address:** the fault is detected on the next FETCH cycle, not in the redirect cycle.
- **Simultaneous push and pop:** allowed when full; count is unchanged and throughput is 1 instruction/cycle.
- **count update:** count + push − pop, except on redirect. Width is clog2(BUF_DEPTH)+1.

## Timing
- **Reset values:**
  - pc = RESET_PC; count = 0; state = FETCH.
  - `if_valid_o` = 0; `if_pc_o` = 0; `if_inst_o` = 0.
  - `fault_o` = 0; `fault_pc_o` = 0.
  - `imem_pc_o` = RESET_PC.
- **After reset release:** the first push happens at the first rising edge with `rst` low. `if_valid_o` rises 1 cycle later with `if_pc_o = RESET_PC`.
- **Redirect latency:** `redirect_valid_i` sampled high at edge N. Target fetched during cycle N+1, pushed at edge N+1. `if_valid_o` is high with `if_pc_o = redirect_pc_i` after edge N+1, i.e. 2 cycles after the redirect was presented. The FIFO is empty (`if_valid_o` = 0) for the cycle between.
- **Halt latency:** `halt_i` high before edge N means no push at edge N. The pc seen on `imem_pc_o` stays constant while halted.
- **Fault latency:** `fault_o` is registered, visible the cycle after the offending pc was on `imem_pc_o`.
- **Mid-operation reset:** asynchronous assertion returns every output to its reset value immediately and discards FIFO contents.
- **Steady state:** with `if_ready_i` held high, one instruction is delivered per cycle at consecutive PCs with no bubbles.

## Test plan
- **Reset + streaming:**
  - Stimulus: memory word i = 32'h1000_0000+i; hold `if_ready_i`=1 from reset.
  - Required: `if_pc_o` = 0,4,8,… on consecutive cycles with matching `if_inst_o`; first valid exactly 1 cycle after `rst` falls.
- **Backpressure:**
  - Stimulus: `if_ready_i`=0 for 5 cycles, then 1.
  - Required: count saturates at 2 and `imem_pc_o` stalls at 8. After release, PCs 0,4,8,12 are delivered in order with no drop or duplicate.
- **Redirect with simultaneous pop:**
  - Stimulus: while `if_valid_o`=1 at pc 0x10 and `if_ready_i`=1, pulse `redirect_valid_i` with 0x40.
  - Required: 0x10 is accepted, then one empty cycle, then `if_pc_o` = 0x40, 0x44, …
- **Halt:**
  - Stimulus: assert `halt_i` for 4 cycles with `if_ready_i`=1.
  - Required: the FIFO drains to empty and `imem_pc_o` is constant. Fetch resumes at the held pc one cycle after `halt_i` drops.
- **Fault:**
  - Stimulus: run sequentially past word 50 (pc 0xCC).
  - Required: `fault_o`=1 with `fault_pc_o`=0xCC; the last delivered pc is 0xC8. A redirect to 0x0 clears `fault_o` and fetching restarts at 0.
- **Misaligned redirect + async reset:**
  - Stimulus: redirect to 0x42.
  - Required: `fault_pc_o`=0x42. A subsequent `rst` pulse between edges immediately clears `fault_o` and `if_valid_o`, with pc = RESET_PC.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory address,
// buffers fetched words in a small FIFO and presents them over a valid/ready handshake.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_DEPTH = 51,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_inst_i,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
    input  logic        if_ready_i,
    output logic        fault_o,
    output logic [31:0] fault_pc_o
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full     = CntW'(BUF_DEPTH);
    localparam logic [31:0]     MemWords = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {StFetch, StHalt, StFault} state_e;

    state_e          state;
    logic [31:0]     pc;
    logic [CntW-1:0] count;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [31:0]     buf_pc   [BUF_DEPTH];
    logic [31:0]     buf_inst [BUF_DEPTH];

    logic addr_ok;
    logic pop;
    logic can_fetch;
    logic push;

    // Fetch/pop qualification; a full FIFO still accepts a push when the head leaves
    always_comb begin
        addr_ok   = (pc[1:0] == 2'b00) && ({2'b00, pc[31:2]} < MemWords);
        pop       = if_valid_o && if_ready_i;
        can_fetch = (state == StFetch) && !halt_i && !redirect_valid_i;
        push      = can_fetch && addr_ok && ((count < Full) || pop);
    end

    assign imem_pc_o  = pc;
    assign if_valid_o = (count != '0);
    assign if_pc_o    = buf_pc[rd_ptr];
    assign if_inst_o  = buf_inst[rd_ptr];

    // Control FSM: PC sequencing, halt tracking and fault capture; redirect wins over all
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StFetch;
            pc         <= RESET_PC;
            fault_o    <= 1'b0;
            fault_pc_o <= '0;
        end else if (redirect_valid_i) begin
            pc      <= redirect_pc_i;
            fault_o <= 1'b0;
            state   <= halt_i ? StHalt : StFetch;
        end else begin
            unique case (state)
                StFetch: begin
                    if (halt_i) begin
                        state <= StHalt;
                    end else if (!addr_ok) begin
                        state      <= StFault;
                        fault_o    <= 1'b1;
                        fault_pc_o <= pc;
                    end else if (push) begin
                        pc <= pc + 32'd4;
                    end
                end
                StHalt: begin
                    if (!halt_i) state <= StFetch;
                end
                StFault: begin
                    state <= StFault;
                end
                default: state <= StFetch;
            endcase
        end
    end

    // Fetch FIFO; a redirect flushes it but a same-cycle pop has already transferred
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_pc[i]   <= '0;
                buf_inst[i] <= '0;
            end
        end else if (redirect_valid_i) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr]   <= pc;
                buf_inst[wr_ptr] <= imem_inst_i;
            end
            wr_ptr <= wr_ptr + PtrW'(push);
            rd_ptr <= rd_ptr + PtrW'(pop);
            count  <= count + CntW'(push) - CntW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table and corner sequences, then random
// traffic, all compared against a queue-based reference model.
module tb_fetch_controller;

    localparam int unsigned MEM_DEPTH = 51;
    localparam int unsigned BUF_DEPTH = 2;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fault;
    logic [31:0] fault_pc;

    int checks = 0;
    int errors = 0;

    fetch_controller #(
        .RESET_PC (RESET_PC),
        .MEM_DEPTH(MEM_DEPTH),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect_valid_i(redirect_valid),
        .redirect_pc_i   (redirect_pc),
        .halt_i          (halt),
        .imem_pc_o       (imem_pc),
        .imem_inst_i     (imem_inst),
        .if_valid_o      (if_valid),
        .if_pc_o         (if_pc),
        .if_inst_o       (if_inst),
        .if_ready_i      (ready),
        .fault_o         (fault),
        .fault_pc_o      (fault_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign imem_inst = mem_word(imem_pc);

    // Reference model: a queue of fetched entries plus a mode word
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] delivered[$];
    logic [31:0] m_pc;
    int          m_mode;  // 0 fetching, 1 halted, 2 faulted
    logic        m_fault;
    logic [31:0] m_fault_pc;

    function automatic bit in_range(input logic [31:0] a);
        return (a % 4 == 0) && ((a / 4) < MEM_DEPTH);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc       = RESET_PC;
        m_mode     = 0;
        m_fault    = 1'b0;
        m_fault_pc = '0;
    endtask

    task automatic model_step();
        bit   pop_m;
        bit   can_push;
        ent_t e;
        pop_m    = (mq.size() != 0) && ready;
        can_push = (mq.size() < BUF_DEPTH) || pop_m;
        if (pop_m) begin
            e = mq.pop_front();
            delivered.push_back(e.pc);
        end
        if (redirect_valid) begin
            mq.delete();
            m_pc    = redirect_pc;
            m_fault = 1'b0;
            m_mode  = halt ? 1 : 0;
        end else begin
            case (m_mode)
                0: begin
                    if (halt) begin
                        m_mode = 1;
                    end else if (!in_range(m_pc)) begin
                        m_mode     = 2;
                        m_fault    = 1'b1;
                        m_fault_pc = m_pc;
                    end else if (can_push) begin
                        e.pc   = m_pc;
                        e.inst = mem_word(m_pc);
                        mq.push_back(e);
                        m_pc = m_pc + 32'd4;
                    end
                end
                1: if (!halt) m_mode = 0;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            chk("if_pc", if_pc, mq[0].pc);
            chk("if_inst", if_inst, mq[0].inst);
        end
        chk("imem_pc", imem_pc, m_pc);
        chk("fault", {31'b0, fault}, {31'b0, m_fault});
        chk("fault_pc", fault_pc, m_fault_pc);
    endtask

    // One clock: model sees the same inputs the DUT samples, outputs checked mid-cycle
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic check_reset_values();
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_fault", {31'b0, fault}, 32'd0);
        chk("rst_fault_pc", fault_pc, 32'd0);
        chk("rst_imem_pc", imem_pc, RESET_PC);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ready;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imem;
    } vec_t;

    vec_t bp_tab[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bp_tab[0] = '{1'b0, 1'b1, 32'h00, 32'h04};
        bp_tab[1] = '{1'b0, 1'b1, 32'h00, 32'h08};
        bp_tab[2] = '{1'b0, 1'b1, 32'h00, 32'h08};
        bp_tab[3] = '{1'b0, 1'b1, 32'h00, 32'h08};
        bp_tab[4] = '{1'b0, 1'b1, 32'h00, 32'h08};
        bp_tab[5] = '{1'b1, 1'b1, 32'h04, 32'h0C};
        bp_tab[6] = '{1'b1, 1'b1, 32'h08, 32'h10};
        bp_tab[7] = '{1'b1, 1'b1, 32'h0C, 32'h14};

        // Reset and streaming with ready held high
        model_reset();
        ready = 1'b1;
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        chk("first_valid_early", {31'b0, if_valid}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("stream_valid", {31'b0, if_valid}, 32'd1);
            chk("stream_pc", if_pc, 32'(4 * k));
            chk("stream_inst", if_inst, 32'h1000_0000 + 32'(k));
        end

        // Backpressure from a fresh reset
        do_reset();
        delivered.delete();
        for (int r = 0; r < 8; r++) begin
            ready = bp_tab[r].ready;
            tick();
            chk("bp_valid", {31'b0, if_valid}, {31'b0, bp_tab[r].valid});
            chk("bp_pc", if_pc, bp_tab[r].pc);
            chk("bp_imem", imem_pc, bp_tab[r].imem);
        end
        chk("bp_order_n", 32'(delivered.size()), 32'd3);
        for (int i = 0; i < delivered.size(); i++) chk("bp_order", delivered[i], 32'(4 * i));

        // Redirect while the head at 0x10 is being accepted
        ready = 1'b1;
        tick();
        chk("rd_head", if_pc, 32'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("rd_taken", delivered[$], 32'h10);
        chk("rd_bubble", {31'b0, if_valid}, 32'd0);
        chk("rd_imem", imem_pc, 32'h40);
        tick();
        chk("rd_valid", {31'b0, if_valid}, 32'd1);
        chk("rd_pc0", if_pc, 32'h40);
        tick();
        chk("rd_pc1", if_pc, 32'h44);
        chk("rd_seq", delivered[$], 32'h40);

        // Halt for four cycles
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_imem", imem_pc, 32'h48);
        end
        chk("halt_drained", {31'b0, if_valid}, 32'd0);
        halt = 1'b0;
        tick();
        chk("halt_exit_gap", {31'b0, if_valid}, 32'd0);
        tick();
        chk("halt_resume_valid", {31'b0, if_valid}, 32'd1);
        chk("halt_resume_pc", if_pc, 32'h48);

        // Run past the end of memory
        begin
            int n = 0;
            while (!fault && n < 100) begin
                tick();
                n++;
            end
            chk("fault_reached", {31'b0, fault}, 32'd1);
        end
        chk("fault_pc_end", fault_pc, 32'hCC);
        chk("fault_last", delivered[$], 32'hC8);
        tick();
        tick();
        chk("fault_hold_imem", imem_pc, 32'hCC);
        chk("fault_hold_valid", {31'b0, if_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        tick();
        redirect_valid = 1'b0;
        chk("fault_clear", {31'b0, fault}, 32'd0);
        tick();
        chk("fault_restart", if_pc, 32'h0);

        // Misaligned redirect, then asynchronous reset between edges
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        tick();
        redirect_valid = 1'b0;
        chk("mis_nofault_yet", {31'b0, fault}, 32'd0);
        tick();
        chk("mis_fault", {31'b0, fault}, 32'd1);
        chk("mis_fault_pc", fault_pc, 32'h42);
        #2;
        do_reset();

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) halt = ~halt;
            redirect_valid = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 9))
                0:       redirect_pc = 32'($urandom_range(0, 255));
                1:       redirect_pc = 32'hFFFF_FFFC;
                default: redirect_pc = 32'($urandom_range(0, 55)) << 2;
            endcase
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
